// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: video read port, CPU read/write port and the RAM drive.
// Optional RAM_ARB_STATS_EN adds the stall-statistics signals.
interface ram_arbiter_if #(
  parameter int unsigned Bits = 16
);
  logic            vidReq;
  logic [Bits-1:0] vidAddress;
  logic            vidAck;
  logic            vidValid;
  logic [7:0]      vidData;

  logic            cpuReq;
  logic            cpuWrite;
  logic [Bits-1:0] cpuAddress;
  logic [7:0]      cpuDataIn;
  logic            cpuAck;
  logic            cpuValid;
  logic [7:0]      cpuDataOut;

  logic            ramWriteEnabled;
  logic [Bits-1:0] ramAddress;
  logic [7:0]      ramDataOut;
  logic [7:0]      ramDataIn;

`ifdef RAM_ARB_STATS_EN
  logic            statClear;
  logic [15:0]     cpuStallCount;
  logic [15:0]     vidStallCount;

  modport master (
    output vidReq, vidAddress, cpuReq, cpuWrite, cpuAddress, cpuDataIn, ramDataIn, statClear,
    input  vidAck, vidValid, vidData, cpuAck, cpuValid, cpuDataOut,
    input  ramWriteEnabled, ramAddress, ramDataOut, cpuStallCount, vidStallCount
  );

  modport slave (
    input  vidReq, vidAddress, cpuReq, cpuWrite, cpuAddress, cpuDataIn, ramDataIn, statClear,
    output vidAck, vidValid, vidData, cpuAck, cpuValid, cpuDataOut,
    output ramWriteEnabled, ramAddress, ramDataOut, cpuStallCount, vidStallCount
  );
`else
  modport master (
    output vidReq, vidAddress, cpuReq, cpuWrite, cpuAddress, cpuDataIn, ramDataIn,
    input  vidAck, vidValid, vidData, cpuAck, cpuValid, cpuDataOut,
    input  ramWriteEnabled, ramAddress, ramDataOut
  );

  modport slave (
    input  vidReq, vidAddress, cpuReq, cpuWrite, cpuAddress, cpuDataIn, ramDataIn,
    output vidAck, vidValid, vidData, cpuAck, cpuValid, cpuDataOut,
    output ramWriteEnabled, ramAddress, ramDataOut
  );
`endif
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the single-port RAM: video has priority, CPU starvation bounded.
// Define RAM_ARB_STATS_EN to add the saturating stall counters and statClear.
module ram_arbiter #(
  parameter int unsigned Bits        = 16,
  parameter int unsigned StarveLimit = 3
) (
  input logic           clk,
  input logic           reset,
  ram_arbiter_if.slave  bus
);

  localparam logic [3:0] Limit = StarveLimit[3:0];

  logic            cpu_sel;
  logic            vid_sel;
  logic [Bits-1:0] ram_addr;
  logic [3:0]      wait_q, wait_d;
  logic            vid_valid_q, cpu_valid_q;
  logic [7:0]      vid_data_q, cpu_data_q;

  // Grants are gated by reset so nothing reaches the RAM while reset is held.
  always_comb begin
    cpu_sel = !reset && bus.cpuReq && (!bus.vidReq || (wait_q == Limit));
    vid_sel = !reset && bus.vidReq && !cpu_sel;
    if (cpu_sel) begin
      ram_addr = bus.cpuAddress;
    end else if (vid_sel) begin
      ram_addr = bus.vidAddress;
    end else begin
      ram_addr = '0;
    end
  end

  always_comb begin
    wait_d = '0;
    if (bus.cpuReq && !cpu_sel) begin
      wait_d = (wait_q >= Limit) ? Limit : wait_q + 4'd1;
    end
  end

  assign bus.vidAck          = vid_sel;
  assign bus.cpuAck          = cpu_sel;
  assign bus.ramAddress      = ram_addr;
  assign bus.ramWriteEnabled = cpu_sel && bus.cpuWrite;
  assign bus.ramDataOut      = bus.cpuDataIn;
  assign bus.vidValid        = vid_valid_q;
  assign bus.vidData         = vid_data_q;
  assign bus.cpuValid        = cpu_valid_q;
  assign bus.cpuDataOut      = cpu_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q      <= '0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= '0;
      cpu_valid_q <= 1'b0;
      cpu_data_q  <= '0;
    end else begin
      wait_q      <= wait_d;
      vid_valid_q <= vid_sel;
      cpu_valid_q <= cpu_sel && !bus.cpuWrite;
      if (vid_sel) begin
        vid_data_q <= bus.ramDataIn;
      end
      if (cpu_sel && !bus.cpuWrite) begin
        cpu_data_q <= bus.ramDataIn;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] cpu_stall_q, vid_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_stall_q <= '0;
      vid_stall_q <= '0;
    end else if (bus.statClear) begin
      cpu_stall_q <= '0;
      vid_stall_q <= '0;
    end else begin
      if (bus.cpuReq && !cpu_sel && (cpu_stall_q != 16'hFFFF)) begin
        cpu_stall_q <= cpu_stall_q + 16'd1;
      end
      if (bus.vidReq && !vid_sel && (vid_stall_q != 16'hFFFF)) begin
        vid_stall_q <= vid_stall_q + 16'd1;
      end
    end
  end

  assign bus.cpuStallCount = cpu_stall_q;
  assign bus.vidStallCount = vid_stall_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus constrained-random traffic
// against a cycle-level reference model and a bench-side RAM.
module tb_ram_arbiter;

  localparam int unsigned Bits        = 16;
  localparam int unsigned StarveLimit = 3;

  logic clk;
  logic reset;

  ram_arbiter_if #(.Bits(Bits)) bus ();

  ram_arbiter #(
    .Bits        (Bits),
    .StarveLimit (StarveLimit)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side RAM (combinational read) and the model's view of its contents.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign bus.ramDataIn = mem[bus.ramAddress];

  int n_checks;
  int n_errors;

  // Reference model state.
  int         losses;
  logic       exp_vv, exp_cv;
  logic [7:0] exp_vd, exp_cd;
  logic       m_vid, m_cpu;

  logic       last_vid_ack, last_cpu_ack;
  logic [7:0] last_vid_data, last_cpu_data;
  logic       last_vid_valid, last_cpu_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    losses = 0;
    exp_vv = 1'b0;
    exp_cv = 1'b0;
    exp_vd = 8'h00;
    exp_cd = 8'h00;
  endtask

  // One clock cycle; entered and left just after a posedge.
  task automatic cycle(input logic vr, input logic [15:0] va, input logic cr, input logic cw,
                       input logic [15:0] ca, input logic [7:0] cd);
    logic        we;
    logic [15:0] wa;
    logic [7:0]  wd;
    bus.vidReq     = vr;
    bus.vidAddress = va;
    bus.cpuReq     = cr;
    bus.cpuWrite   = cw;
    bus.cpuAddress = ca;
    bus.cpuDataIn  = cd;
    #1;
    m_cpu = cr && (!vr || losses == StarveLimit);
    m_vid = vr && !m_cpu;
    check("vidAck", bus.vidAck, m_vid);
    check("cpuAck", bus.cpuAck, m_cpu);
    check("ramWriteEnabled", bus.ramWriteEnabled, m_cpu && cw);
    check("ramAddress", bus.ramAddress, m_cpu ? ca : (m_vid ? va : 16'h0000));
    if (m_cpu && cw) check("ramDataOut", bus.ramDataOut, cd);
    last_vid_ack = bus.vidAck;
    last_cpu_ack = bus.cpuAck;
    we = bus.ramWriteEnabled;
    wa = bus.ramAddress;
    wd = bus.ramDataOut;
    @(posedge clk);
    if (we) mem[wa] = wd;
    exp_vv = m_vid;
    if (m_vid) exp_vd = ref_mem[va];
    exp_cv = m_cpu && !cw;
    if (m_cpu && !cw) exp_cd = ref_mem[ca];
    if (m_cpu && cw) ref_mem[ca] = cd;
    if (cr && !m_cpu) losses = (losses + 1 > StarveLimit) ? StarveLimit : losses + 1;
    else losses = 0;
    #1;
    check("vidValid", bus.vidValid, exp_vv);
    check("vidData", bus.vidData, exp_vd);
    check("cpuValid", bus.cpuValid, exp_cv);
    check("cpuDataOut", bus.cpuDataOut, exp_cd);
    last_vid_valid = bus.vidValid;
    last_vid_data  = bus.vidData;
    last_cpu_valid = bus.cpuValid;
    last_cpu_data  = bus.cpuDataOut;
  endtask

  task automatic apply_reset();
    bus.vidReq     = 1'b0;
    bus.cpuReq     = 1'b1;
    bus.cpuWrite   = 1'b1;
    bus.cpuAddress = 16'h3000;
    bus.cpuDataIn  = 8'h11;
    reset = 1'b1;
    #2;
    check("rst_cpuAck", bus.cpuAck, 1'b0);
    check("rst_vidAck", bus.vidAck, 1'b0);
    check("rst_we", bus.ramWriteEnabled, 1'b0);
    check("rst_addr", bus.ramAddress, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_vidValid", bus.vidValid, 1'b0);
    check("rst_cpuValid", bus.cpuValid, 1'b0);
    check("rst_vidData", bus.vidData, 8'h00);
    check("rst_cpuDataOut", bus.cpuDataOut, 8'h00);
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [15:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return (r[4] ? 16'h2000 : 16'h0000) | {12'h000, r[3:0]};
  endfunction

  logic [7:0] burst_exp [0:7];

  initial begin
    logic        vpend, cpend, cwr;
    logic [15:0] vaddr, caddr;
    logic [7:0]  cdat;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.vidReq = 1'b0;
    bus.vidAddress = '0;
    bus.cpuReq = 1'b0;
    bus.cpuWrite = 1'b0;
    bus.cpuAddress = '0;
    bus.cpuDataIn = '0;
`ifdef RAM_ARB_STATS_EN
    bus.statClear = 1'b0;
`endif
    burst_exp = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h02, 8'h00, 8'h83};
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    for (int i = 0; i < 8; i++) begin
      mem[i]     = burst_exp[i];
      ref_mem[i] = burst_exp[i];
    end
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Request held through reset is granted on the first cycle after release.
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h3000, 8'h11);
    check("post_rst_ack", last_cpu_ack, 1'b1);

    // Write then read back on the next cycle.
    cycle(1'b0, 16'h0000, 1'b1, 1'b1, 16'h2000, 8'h5A);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 16'h2000, 8'h00);
    check("raw_valid", last_cpu_valid, 1'b1);
    check("raw_data", last_cpu_data, 8'h5A);

    // Video burst over the preloaded tilemap bytes.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'(i), 1'b0, 1'b0, 16'h0000, 8'h00);
      check("burst_ack", last_vid_ack, 1'b1);
      check("burst_data", last_vid_data, burst_exp[i]);
    end
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
    check("burst_end_valid", last_vid_valid, 1'b0);

    // Reset landing in the middle of an acked CPU read.
    bus.cpuReq = 1'b1;
    bus.cpuWrite = 1'b0;
    bus.cpuAddress = 16'h2000;
    #1;
    check("mid_ack", bus.cpuAck, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_ack_rst", bus.cpuAck, 1'b0);
    @(posedge clk);
    #1;
    check("mid_valid", bus.cpuValid, 1'b0);
    check("mid_data", bus.cpuDataOut, 8'h00);
    reset = 1'b0;
    model_reset();

    // Starvation: CPU wins cycles 3 and 7 against continuous video.
`ifdef RAM_ARB_STATS_EN
    bus.statClear = 1'b1;
`endif
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
`ifdef RAM_ARB_STATS_EN
    bus.statClear = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
`ifdef RAM_ARB_STATS_EN
      bus.statClear = (i == 4);
`endif
      cycle(1'b1, 16'(i), 1'b1, 1'b0, 16'h2001, 8'h00);
      check("starve_cpuAck", last_cpu_ack, (i == 3) || (i == 7));
      check("starve_vidAck", last_vid_ack, !((i == 3) || (i == 7)));
`ifdef RAM_ARB_STATS_EN
      if (i == 3) check("stat_cpu", bus.cpuStallCount, 16'd3);
      if (i == 4) check("stat_clear", bus.cpuStallCount, 16'd0);
      bus.statClear = 1'b0;
`endif
    end

    // Constrained-random traffic respecting the hold-until-ack protocol.
    vpend = 1'b0;
    cpend = 1'b0;
    vaddr = '0;
    caddr = '0;
    cwr   = 1'b0;
    cdat  = '0;
    for (int k = 0; k < 400; k++) begin
      if (!vpend && $urandom_range(0, 2) != 0) begin
        vpend = 1'b1;
        vaddr = rand_addr();
      end
      if (!cpend && $urandom_range(0, 1) != 0) begin
        cpend = 1'b1;
        caddr = rand_addr();
        cwr   = 1'($urandom_range(0, 1));
        cdat  = 8'($urandom);
      end
      cycle(vpend, vaddr, cpend, cwr, caddr, cdat);
      if (m_vid) vpend = 1'b0;
      if (m_cpu) cpend = 1'b0;
    end

    // Idle: nothing granted, nothing written, no valids.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
    end
    check("idle_valid", last_cpu_valid | last_vid_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
